// File: rtl/mips_muldiv_unit.sv
// ============================================================================
// Module      : mips_muldiv_unit
// Description : Iterative MIPS multiply/divide unit holding HI/LO. Optional
//               single-cycle multiplier enabled by MULDIV_FAST_MULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_muldiv_unit #(
    parameter logic [31:0] RESET_HILO = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [2:0] c_op_mfhi = 3'b000;
    localparam logic [2:0] c_op_mflo = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_stall;
    logic        w_run_done;

    logic [4:0]  r_cnt;
    logic [1:0]  r_kind;      // op[1:0] of the accepted long op
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_b_zero;
    logic [31:0] r_opa;       // |a| multiplicand or |b| divisor
    logic [63:0] r_acc;       // product, or dividend/quotient in [31:0]
    logic [32:0] r_rem;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;

    logic        w_sgn;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_msum;
    logic [32:0] w_dshift;
    logic [33:0] w_ddiff;
    logic        w_qbit;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_new_hi;
    logic [31:0] w_new_lo;
    logic        w_mt_we;

    assign w_sgn   = ~op[0];
    assign w_abs_a = (w_sgn && a[31]) ? (32'd0 - a) : a;
    assign w_abs_b = (w_sgn && b[31]) ? (32'd0 - b) : b;

    // Shift-add step: conditionally add multiplicand into the upper half, then shift right.
    assign w_msum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opa} : 33'd0);

    // Restoring divide step on magnitudes.
    assign w_dshift = {r_rem[31:0], r_acc[31]};
    assign w_ddiff  = {1'b0, w_dshift} - {2'b00, r_opa};
    assign w_qbit   = ~w_ddiff[33];

    assign w_prod   = r_neg_q ? (64'd0 - r_acc) : r_acc;
    // A zero divisor yields an all-ones quotient; the remainder path already reproduces a.
    assign w_quo    = r_b_zero ? 32'hFFFF_FFFF
                    : (r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
    assign w_rem    = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
    assign w_new_hi = r_kind[1] ? w_rem : w_prod[63:32];
    assign w_new_lo = r_kind[1] ? w_quo : w_prod[31:0];

    assign w_mt_we  = req && !op[2] && op[0] && (r_state != S_RUN);

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] w_fast;
    assign w_fast     = {32'd0, r_opa} * {32'd0, r_acc[31:0]};
    assign w_run_done = (r_cnt == 5'd31) || !r_kind[1];
`else
    assign w_run_done = (r_cnt == 5'd31);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = req && op[2];
                if (req && op[2]) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_stall = req;
                if (w_run_done) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 5'd0;
            r_kind   <= 2'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_opa    <= 32'd0;
            r_acc    <= 64'd0;
            r_rem    <= 33'd0;
            r_hi     <= RESET_HILO;
            r_lo     <= RESET_HILO;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (req && op[2]) begin
                        r_cnt    <= 5'd0;
                        r_kind   <= op[1:0];
                        r_neg_q  <= w_sgn && (a[31] ^ b[31]);
                        r_neg_r  <= w_sgn && a[31];
                        r_b_zero <= (b == 32'd0);
                        r_rem    <= 33'd0;
                        if (op[1]) begin
                            r_opa <= w_abs_b;
                            r_acc <= {32'd0, w_abs_a};
                        end else begin
                            r_opa <= w_abs_a;
                            r_acc <= {32'd0, w_abs_b};
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (!r_kind[1]) begin
`ifdef MULDIV_FAST_MULT_EN
                        r_acc <= w_fast;
`else
                        r_acc <= {w_msum, r_acc[31:1]};
`endif
                    end else begin
                        r_rem        <= w_qbit ? w_ddiff[32:0] : w_dshift;
                        r_acc[31:0]  <= {r_acc[30:0], w_qbit};
                    end
                end
                S_FIX: begin
                    r_hi <= w_new_hi;
                    r_lo <= w_new_lo;
                end
                default: begin
                end
            endcase
            // A move completing in FIX was issued after the long op, so it wins.
            if (w_mt_we) begin
                if (op[1]) begin
                    r_lo <= a;
                end else begin
                    r_hi <= a;
                end
            end
        end
    end

    // In FIX the committing result is forwarded so a stalled MFHI/MFLO reads it.
    always_comb begin
        rd_data = 32'd0;
        if (op == c_op_mfhi) begin
            rd_data = (r_state == S_FIX) ? w_new_hi : r_hi;
        end else if (op == c_op_mflo) begin
            rd_data = (r_state == S_FIX) ? w_new_lo : r_lo;
        end
    end

    assign stall = w_stall;
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
// ============================================================================
// Module      : tb_mips_muldiv_unit
// Description : Directed self-checking bench for mips_muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
    localparam int c_mul_stalls = 2;
`else
    localparam int c_mul_stalls = 33;
`endif
    localparam int c_div_stalls = 33;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_vec;
    int n_fail;
    int ns;

    mips_muldiv_unit #(
        .RESET_HILO(32'h0000_0000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op      (op),
        .a       (a),
        .b       (b),
        .stall   (stall),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a long op, count stalled cycles (bounded), drop req after completion.
    task automatic do_long(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int n);
        @(posedge clk); #1;
        req = 1'b1; op = o; a = x; b = y;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n >= 2) begin
                a = ~x;
                b = ~y;
            end
        end
        @(posedge clk); #1;
        req = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_fail = 0;
        rst_n = 1'b0; req = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        @(negedge clk);
        check("reset_hi",    hi,            32'h0);
        check("reset_lo",    lo,            32'h0);
        check("reset_busy",  {31'd0, busy}, 32'h0);
        check("reset_stall", {31'd0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULT -3 * 7
        do_long(3'b100, 32'hFFFF_FFFD, 32'd7, ns);
        check("mult_stalls", 32'(ns), 32'(c_mul_stalls));
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        check("mult_busy", {31'd0, busy}, 32'h0);

        // MULTU max * max
        do_long(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ns);
        check("multu_stalls", 32'(ns), 32'(c_mul_stalls));
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2
        do_long(3'b110, 32'hFFFF_FFF9, 32'd2, ns);
        check("div_stalls", 32'(ns), 32'(c_div_stalls));
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 7 / 2
        do_long(3'b111, 32'd7, 32'd2, ns);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        // Divide by zero, positive and negative dividend
        do_long(3'b110, 32'h0000_1234, 32'd0, ns);
        check("div0_stalls", 32'(ns), 32'(c_div_stalls));
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'h0000_1234);
        do_long(3'b110, 32'hFFFF_FFF9, 32'd0, ns);
        check("div0n_lo", lo, 32'hFFFF_FFFF);
        check("div0n_hi", hi, 32'hFFFF_FFF9);

        // Signed overflow
        do_long(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, ns);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);

        // MTHI then MFHI
        @(posedge clk); #1;
        req = 1'b1; op = 3'b001; a = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi_stall", {31'd0, stall}, 32'h0);
        @(posedge clk); #1;
        op = 3'b000; a = 32'd0;
        @(negedge clk);
        check("mfhi_rd", rd_data, 32'hDEAD_BEEF);
        check("mfhi_stall", {31'd0, stall}, 32'h0);
        @(posedge clk); #1;
        req = 1'b0;

        // MFLO issued while a DIVU 100/7 runs
        @(posedge clk); #1;
        req = 1'b1; op = 3'b111; a = 32'd100; b = 32'd7;
        @(negedge clk);
        check("mflo_acc_stall", {31'd0, stall}, 32'h1);
        @(posedge clk); #1;
        op = 3'b010; a = 32'd0; b = 32'd0;
        ns = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stall) break;
            ns++;
        end
        check("mflo_run_stalls", 32'(ns), 32'd32);
        check("mflo_fix_busy", {31'd0, busy}, 32'h1);
        check("mflo_fix_rd", rd_data, 32'd14);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("mflo_after_rd", rd_data, 32'd14);
        check("mflo_after_lo", lo, 32'd14);
        check("mflo_after_hi", hi, 32'd2);
        check("mflo_after_busy", {31'd0, busy}, 32'h0);

        // Reset at RUN iteration 10
        @(posedge clk); #1;
        req = 1'b1; op = 3'b101; a = 32'h1234_5678; b = 32'd9;
        repeat (12) @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'h1);
        #1;
        rst_n = 1'b0; req = 1'b0;
        #1;
        check("rst_mid_busy",  {31'd0, busy},  32'h0);
        check("rst_mid_stall", {31'd0, stall}, 32'h0);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_long(3'b101, 32'd3, 32'd5, ns);
        check("post_rst_stalls", 32'(ns), 32'(c_mul_stalls));
        check("post_rst_lo", lo, 32'd15);
        check("post_rst_hi", hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
